// File: rtl/conv_stream_engine.sv
// Sequential 2-D convolution engine: loads a KxK kernel from matrix_mem, slides it over the image
// one tap per cycle and streams saturated results on a valid/ready port with end-of-row markers.
module conv_stream_engine #(
  parameter int unsigned IMG_H = 10,
  parameter int unsigned IMG_W = 12,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned KMAX  = 5,
  parameter int unsigned OUT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_conv,
  input  logic [2:0]               cfg_k,
  input  logic                     cfg_stride2,
  input  logic                     cfg_same,
  input  logic [1:0]               cfg_k_slot,
  output logic [1:0]               mem_rd_slot,
  output logic [2:0]               mem_rd_row,
  output logic [2:0]               mem_rd_col,
  input  logic [15:0]              mem_rd_data,
  output logic [$clog2(IMG_H)-1:0] img_rd_row,
  output logic [$clog2(IMG_W)-1:0] img_rd_col,
  input  logic [PIX_W-1:0]         img_rd_data,
  output logic [OUT_W-1:0]         conv_res_data,
  output logic                     conv_res_valid,
  input  logic                     conv_res_ready,
  output logic                     conv_res_last,
  output logic                     conv_busy,
  output logic                     conv_done,
  output logic                     conv_err
);

  localparam int unsigned RAW   = $clog2(IMG_H);
  localparam int unsigned CAW   = $clog2(IMG_W);
  localparam int unsigned ACC_W = 16 + PIX_W + 1 + 5;
  localparam int unsigned NTAP  = KMAX * KMAX;
  localparam int unsigned TW    = $clog2(NTAP + 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((longint'(1) <<< (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(longint'(1) <<< (OUT_W - 1)));

  typedef enum logic [2:0] {StIdle, StLoadK, StCalc, StEmit, StDone} state_e;

  typedef struct packed {
    logic           oob;
    logic [RAW-1:0] row;
    logic [CAW-1:0] col;
  } tap_t;

  state_e                   state_q;
  logic [2:0]               k_q;
  logic [TW-1:0]            kk_q;
  logic                     stride2_q;
  logic [2:0]               pad_q;
  logic [6:0]               oh_q, ow_q;
  logic [6:0]               r_q, c_q;
  logic [2:0]               ti_q, tj_q;
  logic [TW-1:0]            tcnt_q;
  logic signed [15:0]       kern_q [NTAP];
  logic signed [15:0]       coef_q;
  logic                     pad_pix_q;
  logic                     iss_oob_q;
  logic signed [ACC_W-1:0]  acc_q;

  logic                     cfg_bad;
  logic [6:0]               oh_in, ow_in;
  logic [2:0]               ni, nj;
  logic [6:0]               nr, nc;
  logic                     frame_end;
  logic signed [PIX_W:0]    pix_s;
  logic signed [16+PIX_W:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [OUT_W-1:0]         sat;

  // Image address of tap (i,j) for output (r,c); pad taps present address 0 and raise oob.
  function automatic tap_t tap_addr(input logic [6:0] r, input logic [6:0] c,
                                    input logic [2:0] i, input logic [2:0] j);
    int   y, x;
    tap_t t;
    y = int'(r) * (stride2_q ? 2 : 1) + int'(i) - int'(pad_q);
    x = int'(c) * (stride2_q ? 2 : 1) + int'(j) - int'(pad_q);
    t.oob = (y < 0) || (y >= int'(IMG_H)) || (x < 0) || (x >= int'(IMG_W));
    t.row = t.oob ? '0 : RAW'(y);
    t.col = t.oob ? '0 : CAW'(x);
    return t;
  endfunction

  always_comb begin
    int unsigned s_in, k_in;
    k_in    = 32'(cfg_k);
    s_in    = cfg_stride2 ? 2 : 1;
    cfg_bad = (cfg_k == 3'd0) || (k_in > KMAX) || (k_in > IMG_H) || (k_in > IMG_W) ||
              (cfg_same && !cfg_k[0]);
    oh_in   = '0;
    ow_in   = '0;
    if (!cfg_bad) begin
      if (cfg_same) begin
        oh_in = 7'((IMG_H + s_in - 1) / s_in);
        ow_in = 7'((IMG_W + s_in - 1) / s_in);
      end else begin
        oh_in = 7'((IMG_H - k_in) / s_in + 1);
        ow_in = 7'((IMG_W - k_in) / s_in + 1);
      end
    end
  end

  always_comb begin
    if (tj_q == k_q - 3'd1) begin
      ni = ti_q + 3'd1;
      nj = '0;
    end else begin
      ni = ti_q;
      nj = tj_q + 3'd1;
    end
    if (c_q == ow_q - 7'd1) begin
      nr = r_q + 7'd1;
      nc = '0;
    end else begin
      nr = r_q;
      nc = c_q + 7'd1;
    end
    frame_end = (r_q == oh_q - 7'd1) && (c_q == ow_q - 7'd1);
  end

  // MAC datapath: signed coefficient times zero-extended pixel, pad taps contribute zero.
  always_comb begin
    pix_s   = pad_pix_q ? '0 : {1'b0, img_rd_data};
    prod    = coef_q * pix_s;
    acc_sum = acc_q + ACC_W'(prod);
    if (acc_sum > SAT_MAX) begin
      sat = SAT_MAX[OUT_W-1:0];
    end else if (acc_sum < SAT_MIN) begin
      sat = SAT_MIN[OUT_W-1:0];
    end else begin
      sat = acc_sum[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      k_q            <= '0;
      kk_q           <= '0;
      stride2_q      <= 1'b0;
      pad_q          <= '0;
      oh_q           <= '0;
      ow_q           <= '0;
      r_q            <= '0;
      c_q            <= '0;
      ti_q           <= '0;
      tj_q           <= '0;
      tcnt_q         <= '0;
      kern_q         <= '{default: '0};
      coef_q         <= '0;
      pad_pix_q      <= 1'b0;
      iss_oob_q      <= 1'b0;
      acc_q          <= '0;
      mem_rd_slot    <= '0;
      mem_rd_row     <= '0;
      mem_rd_col     <= '0;
      img_rd_row     <= '0;
      img_rd_col     <= '0;
      conv_res_data  <= '0;
      conv_res_valid <= 1'b0;
      conv_res_last  <= 1'b0;
      conv_busy      <= 1'b0;
      conv_done      <= 1'b0;
      conv_err       <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      conv_err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_conv) begin
            if (cfg_bad) begin
              conv_err <= 1'b1;
            end else begin
              k_q         <= cfg_k;
              kk_q        <= TW'({2'b00, cfg_k} * {2'b00, cfg_k});
              stride2_q   <= cfg_stride2;
              pad_q       <= cfg_same ? ((cfg_k - 3'd1) >> 1) : 3'd0;
              oh_q        <= oh_in;
              ow_q        <= ow_in;
              r_q         <= '0;
              c_q         <= '0;
              ti_q        <= '0;
              tj_q        <= '0;
              tcnt_q      <= '0;
              mem_rd_slot <= cfg_k_slot;
              mem_rd_row  <= '0;
              mem_rd_col  <= '0;
              conv_busy   <= 1'b1;
              state_q     <= StLoadK;
            end
          end
        end

        // Coefficient for tap t arrives one cycle after its address, hence the drain cycle.
        StLoadK: begin
          if (tcnt_q != '0) begin
            kern_q[tcnt_q - TW'(1)] <= mem_rd_data;
          end
          if (tcnt_q == kk_q) begin
            tcnt_q      <= '0;
            ti_q        <= '0;
            tj_q        <= '0;
            mem_rd_slot <= '0;
            mem_rd_row  <= '0;
            mem_rd_col  <= '0;
            {iss_oob_q, img_rd_row, img_rd_col} <= tap_addr(r_q, c_q, 3'd0, 3'd0);
            state_q     <= StCalc;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
            ti_q   <= ni;
            tj_q   <= nj;
            if (tcnt_q + TW'(1) < kk_q) begin
              mem_rd_row <= ni;
              mem_rd_col <= nj;
            end else begin
              mem_rd_slot <= '0;
              mem_rd_row  <= '0;
              mem_rd_col  <= '0;
            end
          end
        end

        StCalc: begin
          acc_q <= (tcnt_q == '0) ? '0 : acc_sum;
          if (tcnt_q == kk_q) begin
            conv_res_data  <= sat;
            conv_res_valid <= 1'b1;
            conv_res_last  <= (c_q == ow_q - 7'd1);
            state_q        <= StEmit;
          end else begin
            coef_q    <= kern_q[tcnt_q];
            pad_pix_q <= iss_oob_q;
            tcnt_q    <= tcnt_q + TW'(1);
            ti_q      <= ni;
            tj_q      <= nj;
            if (tcnt_q + TW'(1) < kk_q) begin
              {iss_oob_q, img_rd_row, img_rd_col} <= tap_addr(r_q, c_q, ni, nj);
            end else begin
              {iss_oob_q, img_rd_row, img_rd_col} <= '0;
            end
          end
        end

        StEmit: begin
          if (conv_res_ready) begin
            conv_res_valid <= 1'b0;
            conv_res_last  <= 1'b0;
            if (frame_end) begin
              state_q <= StDone;
            end else begin
              r_q     <= nr;
              c_q     <= nc;
              tcnt_q  <= '0;
              ti_q    <= '0;
              tj_q    <= '0;
              {iss_oob_q, img_rd_row, img_rd_col} <= tap_addr(nr, nc, 3'd0, 3'd0);
              state_q <= StCalc;
            end
          end
        end

        StDone: begin
          conv_done <= 1'b1;
          conv_busy <= 1'b0;
          state_q   <= StIdle;
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_stream_engine.sv
// Randomised scoreboard bench for conv_stream_engine: a direct-formula convolution model fills
// an expectation queue and a negedge monitor checks every handshake against it.
module tb_conv_stream_engine;

  localparam int IMG_H = 10;
  localparam int IMG_W = 12;
  localparam int PIX_W = 8;
  localparam int KMAX  = 5;
  localparam int OUT_W = 16;
  localparam int RAW   = $clog2(IMG_H);
  localparam int CAW   = $clog2(IMG_W);

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             last;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_conv;
  logic [2:0]       cfg_k;
  logic             cfg_stride2;
  logic             cfg_same;
  logic [1:0]       cfg_k_slot;
  logic [1:0]       mem_rd_slot;
  logic [2:0]       mem_rd_row;
  logic [2:0]       mem_rd_col;
  logic [15:0]      mem_rd_data;
  logic [RAW-1:0]   img_rd_row;
  logic [CAW-1:0]   img_rd_col;
  logic [PIX_W-1:0] img_rd_data;
  logic [OUT_W-1:0] conv_res_data;
  logic             conv_res_valid;
  logic             conv_res_ready;
  logic             conv_res_last;
  logic             conv_busy;
  logic             conv_done;
  logic             conv_err;

  always #5 clk = ~clk;

  conv_stream_engine #(
    .IMG_H(IMG_H), .IMG_W(IMG_W), .PIX_W(PIX_W), .KMAX(KMAX), .OUT_W(OUT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_conv(start_conv), .cfg_k(cfg_k), .cfg_stride2(cfg_stride2),
    .cfg_same(cfg_same), .cfg_k_slot(cfg_k_slot), .mem_rd_slot(mem_rd_slot),
    .mem_rd_row(mem_rd_row), .mem_rd_col(mem_rd_col), .mem_rd_data(mem_rd_data),
    .img_rd_row(img_rd_row), .img_rd_col(img_rd_col), .img_rd_data(img_rd_data),
    .conv_res_data(conv_res_data), .conv_res_valid(conv_res_valid),
    .conv_res_ready(conv_res_ready), .conv_res_last(conv_res_last), .conv_busy(conv_busy),
    .conv_done(conv_done), .conv_err(conv_err)
  );

  logic [15:0] kmem [4][8][8];
  int          pix  [IMG_H][IMG_W];
  exp_t        exp_q[$];

  int     n_checks = 0;
  int     n_fail   = 0;
  int     hs_count = 0;
  int     stall_cnt = 0;
  int     done_cnt = 0;
  int     bp_mode  = 0;
  longint cyc      = 0;
  longint last_hs  = 0;
  bit     img_oob_seen = 0;

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    mem_rd_data <= kmem[mem_rd_slot][mem_rd_row][mem_rd_col];
    if (int'(img_rd_row) < IMG_H && int'(img_rd_col) < IMG_W)
      img_rd_data <= PIX_W'(pix[img_rd_row][img_rd_col]);
    else
      img_rd_data <= 8'hAA;
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_expected(input int k, input bit s2, input bit same, input int slot,
                                output int n);
    int     s, p, oh, ow, y, x;
    longint acc;
    exp_t   e;
    s  = s2 ? 2 : 1;
    p  = same ? (k - 1) / 2 : 0;
    oh = same ? (IMG_H + s - 1) / s : (IMG_H - k) / s + 1;
    ow = same ? (IMG_W + s - 1) / s : (IMG_W - k) / s + 1;
    for (int r = 0; r < oh; r++) begin
      for (int c = 0; c < ow; c++) begin
        acc = 0;
        for (int i = 0; i < k; i++) begin
          for (int j = 0; j < k; j++) begin
            y = r * s + i - p;
            x = c * s + j - p;
            if (y >= 0 && y < IMG_H && x >= 0 && x < IMG_W)
              acc += longint'($signed(kmem[slot][i][j])) * longint'(pix[y][x]);
          end
        end
        if (acc > (longint'(1) <<< (OUT_W - 1)) - 1) acc = (longint'(1) <<< (OUT_W - 1)) - 1;
        else if (acc < -(longint'(1) <<< (OUT_W - 1))) acc = -(longint'(1) <<< (OUT_W - 1));
        e.data = OUT_W'(acc);
        e.last = (c == ow - 1);
        exp_q.push_back(e);
      end
    end
    n = oh * ow;
  endtask

  // Monitor: handshakes are judged at negedge, where valid/ready hold for the next rising edge.
  bit               held = 0;
  logic [OUT_W-1:0] held_data;
  logic             held_last;
  exp_t             got;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
        continue;
      end
      if (conv_done) done_cnt++;
      if (int'(img_rd_row) >= IMG_H || int'(img_rd_col) >= IMG_W) img_oob_seen = 1;
      if (held) begin
        check("hold_valid", conv_res_valid, 1);
        check("hold_data", conv_res_data, held_data);
        check("hold_last", conv_res_last, held_last);
      end
      if (conv_res_valid && conv_res_ready) begin
        if (exp_q.size() == 0) begin
          check("output_expected", exp_q.size(), 1);
        end else begin
          got = exp_q.pop_front();
          check("res_data", conv_res_data, got.data);
          check("res_last", conv_res_last, got.last);
        end
        last_hs = cyc + 1;
        hs_count++;
      end
      held      = conv_res_valid && !conv_res_ready;
      held_data = conv_res_data;
      held_last = conv_res_last;
    end
  end

  // Sink: mode 0 always ready, mode 1 stalls output 3 for five cycles, mode 2 random.
  initial begin
    conv_res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1 && conv_res_valid && hs_count == 3 && stall_cnt < 5) begin
        conv_res_ready = 1'b0;
        stall_cnt++;
      end else if (bp_mode == 2) begin
        conv_res_ready = ($urandom_range(0, 3) != 0);
      end else begin
        conv_res_ready = 1'b1;
      end
    end
  end

  task automatic scramble_cfg();
    cfg_k       = 3'($urandom);
    cfg_stride2 = 1'($urandom);
    cfg_same    = 1'($urandom);
    cfg_k_slot  = 2'($urandom);
  endtask

  task automatic run_frame(input int k, input bit s2, input bit same, input int slot,
                           input int mode, input bit poke, input int exp_lat);
    int n, lat, t;
    exp_q.delete();
    build_expected(k, s2, same, slot, n);
    hs_count = 0; stall_cnt = 0; done_cnt = 0; img_oob_seen = 0; bp_mode = mode;
    @(posedge clk); #1;
    cfg_k = 3'(k); cfg_stride2 = s2; cfg_same = same; cfg_k_slot = 2'(slot);
    start_conv = 1'b1;
    @(posedge clk); #1;
    start_conv = 1'b0;
    scramble_cfg();
    check("busy_after_start", conv_busy, 1);
    check("first_kslot", mem_rd_slot, slot);
    check("first_krow", mem_rd_row, 0);
    check("first_kcol", mem_rd_col, 0);
    if (exp_lat > 0) begin
      lat = 0;
      while (!conv_res_valid && lat < 200) begin
        @(posedge clk); #1;
        lat++;
      end
      check("first_valid_latency", lat, exp_lat);
    end
    if (poke) begin
      repeat (7) @(posedge clk);
      #1;
      scramble_cfg();
      start_conv = 1'b1;
      @(posedge clk); #1;
      start_conv = 1'b0;
    end
    t = 0;
    while (!conv_done && t < 30000) begin
      @(posedge clk); #1;
      t++;
    end
    check("done_seen", conv_done, 1);
    if (conv_done) begin
      check("done_after_last_hs", cyc - last_hs, 1);
      check("busy_low_at_done", conv_busy, 0);
    end
    check("outputs_received", hs_count, n);
    check("outputs_left", exp_q.size(), 0);
    @(posedge clk); #1;
    check("done_pulse_width", conv_done, 0);
    check("done_count", done_cnt, 1);
    if (same) check("img_addr_in_range", img_oob_seen, 0);
    if (mode == 1) check("stall_cycles", stall_cnt, 5);
    exp_q.delete();
    bp_mode = 0;
  endtask

  task automatic run_bad(input int k, input bit same);
    @(posedge clk); #1;
    cfg_k = 3'(k); cfg_stride2 = 1'b0; cfg_same = same; cfg_k_slot = 2'd3;
    start_conv = 1'b1;
    @(posedge clk); #1;
    start_conv = 1'b0;
    check("err_pulse", conv_err, 1);
    check("err_busy", conv_busy, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("err_pulse_width", conv_err, 0);
      check("err_idle_busy", conv_busy, 0);
      check("err_no_valid", conv_res_valid, 0);
      check("err_no_kread", mem_rd_slot, 0);
    end
  endtask

  task automatic fill_slot(input int slot, input logic [15:0] v, input bit rnd);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        kmem[slot][i][j] = rnd ? 16'($urandom) : v;
  endtask

  task automatic fill_pix(input int mode);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        pix[r][c] = (mode == 0) ? 12 * r + c : (mode == 1) ? 255 : int'($urandom_range(0, 255));
  endtask

  initial begin
    int k;
    bit same;
    rst = 1'b1;
    start_conv = 1'b0;
    cfg_k = '0; cfg_stride2 = 1'b0; cfg_same = 1'b0; cfg_k_slot = '0;
    for (int s = 0; s < 4; s++) fill_slot(s, 16'd0, 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        kmem[0][i][j] = ((i + j) % 2 == 0) ? 16'd1 : 16'd0;
    fill_pix(0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", conv_res_valid, 0);
    check("rst_last", conv_res_last, 0);
    check("rst_data", conv_res_data, 0);
    check("rst_busy", conv_busy, 0);
    check("rst_done", conv_done, 0);
    check("rst_err", conv_err, 0);
    check("rst_img_row", img_rd_row, 0);
    check("rst_krow", mem_rd_row, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(3, 0, 0, 0, 0, 0, 20);
    run_frame(3, 1, 0, 0, 0, 0, 0);
    run_frame(3, 0, 1, 0, 0, 0, 0);

    fill_slot(1, 16'h7FFF, 0);
    fill_slot(2, 16'h8000, 0);
    fill_pix(1);
    run_frame(3, 0, 0, 1, 0, 0, 0);
    run_frame(3, 0, 0, 2, 0, 0, 0);
    fill_pix(0);

    run_frame(3, 0, 0, 0, 1, 1, 0);

    run_bad(4, 1);
    run_bad(6, 0);
    run_bad(0, 0);

    // Reset in the middle of CALC, then a complete frame from a fresh start.
    @(posedge clk); #1;
    cfg_k = 3'd3; cfg_stride2 = 1'b0; cfg_same = 1'b0; cfg_k_slot = 2'd0;
    start_conv = 1'b1;
    @(posedge clk); #1;
    start_conv = 1'b0;
    repeat (13) @(posedge clk);
    #3;
    check("busy_before_reset", conv_busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", conv_res_valid, 0);
    check("midrst_last", conv_res_last, 0);
    check("midrst_data", conv_res_data, 0);
    check("midrst_busy", conv_busy, 0);
    check("midrst_done", conv_done, 0);
    check("midrst_err", conv_err, 0);
    check("midrst_img_col", img_rd_col, 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("idle_after_reset", conv_busy, 0);
    run_frame(3, 0, 0, 0, 0, 0, 20);

    for (int n = 0; n < 6; n++) begin
      k    = $urandom_range(1, KMAX);
      same = 1'($urandom_range(0, 1));
      if (same && (k % 2 == 0)) k = k - 1;
      fill_slot(3, 16'd0, 1);
      fill_pix(2);
      run_frame(k, 1'($urandom_range(0, 1)), same, 3, 2, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
